// File: rtl/jk_excite_pkg.sv
// Shared definitions for the JK excitation controller: FSM encoding,
// the per-bit excitation table and a popcount helper.
package jk_excite_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] DRIVE = 3'd1;
  localparam logic [2:0] APPLY = 3'd2;
  localparam logic [2:0] CHECK = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  // Returns {J,K} steering q_bit to t_bit; don't-cares resolve to tog.
  function automatic logic [1:0] excite(input logic q_bit, input logic t_bit, input logic tog);
    logic [1:0] jk;
    unique case ({q_bit, t_bit})
      2'b00:   jk = {1'b0, tog};
      2'b01:   jk = {1'b1, tog};
      2'b10:   jk = {tog, 1'b1};
      default: jk = {tog, 1'b0};
    endcase
    return jk;
  endfunction

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) cnt++;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/jk_bit_ff.sv
// Single JK flip-flop with asynchronous active-high reset to 0.
module jk_bit_ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_j,
  input  logic i_k,
  output logic o_q
);

  logic r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q <= 1'b0;
    end else begin
      case ({i_j, i_k})
        2'b01:   r_q <= 1'b0;
        2'b10:   r_q <= 1'b1;
        2'b11:   r_q <= ~r_q;
        default: r_q <= r_q;
      endcase
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/jk_excite_ctrl.sv
// Steers an internal JK bank to a requested state word via the excitation
// table, exposes the J/K drive, and reports match/bit-change count.
module jk_excite_ctrl
  import jk_excite_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter bit          TOGGLE_X = 1'b0,
  localparam int unsigned CW      = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_tgt_valid,
  input  logic [WIDTH-1:0] i_tgt_data,
  output logic             o_tgt_ready,
  output logic [WIDTH-1:0] o_j_out,
  output logic [WIDTH-1:0] o_k_out,
  output logic [WIDTH-1:0] o_q,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_match,
  output logic [CW-1:0]    o_changed
);

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [WIDTH-1:0] r_tgt;
  logic [WIDTH-1:0] r_q_old;
  logic [WIDTH-1:0] r_j;
  logic [WIDTH-1:0] r_k;
  logic             r_match;
  logic [CW-1:0]    r_changed;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_exc_j;
  logic [WIDTH-1:0] w_exc_k;

  // J/K are zero outside APPLY, so the bank holds in every other cycle.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bank
    assign {w_exc_j[gi], w_exc_k[gi]} = excite(w_q[gi], r_tgt[gi], TOGGLE_X);

    jk_bit_ff u_ff (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_j   (r_j[gi]),
      .i_k   (r_k[gi]),
      .o_q   (w_q[gi])
    );
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_tgt_valid) w_state_nxt = DRIVE;
      DRIVE:   w_state_nxt = APPLY;
      APPLY:   w_state_nxt = CHECK;
      CHECK:   w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_tgt     <= '0;
      r_q_old   <= '0;
      r_j       <= '0;
      r_k       <= '0;
      r_match   <= 1'b0;
      r_changed <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (i_tgt_valid) begin
            r_tgt   <= i_tgt_data;
            r_q_old <= w_q;
          end
        end
        DRIVE: begin
          r_j <= w_exc_j;
          r_k <= w_exc_k;
        end
        APPLY: begin
          r_j <= '0;
          r_k <= '0;
        end
        CHECK: begin
          r_match   <= (w_q == r_tgt);
          r_changed <= CW'(popcount(32'(r_q_old ^ r_tgt)));
        end
        default: ;
      endcase
    end
  end

  assign o_tgt_ready = (r_state == IDLE);
  assign o_busy      = (r_state != IDLE);
  assign o_done      = (r_state == DONE);
  assign o_j_out     = r_j;
  assign o_k_out     = r_k;
  assign o_q         = w_q;
  assign o_match     = r_match;
  assign o_changed   = r_changed;

endmodule
